// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: issues one fetch block per cycle to the I-cache and steers the PC on flush/predictor redirects.
// Optional performance counters are built when FETCH_PC_GEN_PERF_EN is defined.
`ifndef EXCEPTION_NOP
`define EXCEPTION_NOP 7'h00
`endif
`ifndef EXCEPTION_ADEF
`define EXCEPTION_ADEF 7'h08
`endif

module fetch_pc_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           iuncache,
  input  logic                           flush,
  input  logic [31:0]                    flush_pc,
  input  logic                           bpu_taken,
  input  logic [31:0]                    bpu_target,
  output logic                           fetch_valid,
  input  logic                           fetch_ready,
  output logic [31:0]                    fetch_pc,
  output logic [FETCH_WIDTH-1:0]         fetch_mask,
  output logic [$clog2(FETCH_WIDTH):0]   fetch_count,
  output logic                           pc_is_exception,
`ifdef FETCH_PC_GEN_PERF_EN
  output logic [31:0]                    perf_fetch_blocks,
  output logic [31:0]                    perf_redirects,
`endif
  output logic [6:0]                     pc_exception_cause
);

  localparam int CW = $clog2(FETCH_WIDTH) + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [31:0] pc, next_pc;
  logic [CW-1:0] base_count;
  logic [CW-1:0] count;
  logic        misaligned;
  logic        accept;

  assign misaligned = (pc[1:0] != 2'b00);

  // Blocks end at the FETCH_WIDTH*4-byte boundary, so the slot offset shortens the block.
  generate
    if (FETCH_WIDTH == 1) begin : g_single
      assign base_count = CW'(1);
    end else begin : g_multi
      localparam int OW = $clog2(FETCH_WIDTH);
      logic [OW-1:0] slot;
      assign slot       = pc[OW+1:2];
      assign base_count = CW'(FETCH_WIDTH) - {1'b0, slot};
    end
  endgenerate

  assign count = (iuncache || misaligned) ? CW'(1) : base_count;

  always_comb begin
    fetch_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      fetch_mask[i] = (CW'(i) < count);
    end
  end

  assign fetch_valid        = (state == RUN) && !stall && !flush && !bpu_taken;
  assign accept             = fetch_valid && fetch_ready;
  assign fetch_pc           = pc;
  assign fetch_count        = count;
  assign pc_is_exception    = misaligned;
  assign pc_exception_cause = misaligned ? `EXCEPTION_ADEF : `EXCEPTION_NOP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // Flush overrides everything, including the parked exception state; the predictor only steers in RUN.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    if (flush) begin
      next_pc    = flush_pc;
      next_state = RUN;
    end else begin
      case (state)
        BOOT: next_state = RUN;
        RUN: begin
          if (bpu_taken) begin
            next_pc = bpu_target;
          end else if (accept) begin
            if (misaligned) next_state = EXC;
            else            next_pc    = pc + (32'(count) << 2);
          end
        end
        EXC:     next_state = EXC;
        default: next_state = BOOT;
      endcase
    end
  end

`ifdef FETCH_PC_GEN_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_blocks <= '0;
      perf_redirects    <= '0;
    end else begin
      if (accept) perf_fetch_blocks <= perf_fetch_blocks + 32'd1;
      if (flush || (bpu_taken && state == RUN)) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen with FETCH_WIDTH=4.
// Exercises perf counters only when FETCH_PC_GEN_PERF_EN is defined.
`timescale 1ns/1ps
`ifndef EXCEPTION_NOP
`define EXCEPTION_NOP 7'h00
`endif
`ifndef EXCEPTION_ADEF
`define EXCEPTION_ADEF 7'h08
`endif

module tb_fetch_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n, stall, iuncache, flush, bpu_taken, fetch_ready;
  logic [31:0] flush_pc, bpu_target;
  logic        fetch_valid, pc_is_exception;
  logic [31:0] fetch_pc;
  logic [3:0]  fetch_mask;
  logic [2:0]  fetch_count;
  logic [6:0]  pc_exception_cause;
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0] perf_fetch_blocks, perf_redirects;
`endif
  int checks = 0;
  int errors = 0;

  fetch_pc_gen #(.FETCH_WIDTH(4), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .iuncache(iuncache),
    .flush(flush), .flush_pc(flush_pc), .bpu_taken(bpu_taken), .bpu_target(bpu_target),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_mask(fetch_mask), .fetch_count(fetch_count), .pc_is_exception(pc_is_exception),
`ifdef FETCH_PC_GEN_PERF_EN
    .perf_fetch_blocks(perf_fetch_blocks), .perf_redirects(perf_redirects),
`endif
    .pc_exception_cause(pc_exception_cause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; iuncache = 0; flush = 0; bpu_taken = 0; fetch_ready = 1;
    flush_pc = '0; bpu_target = '0;
    step();
    checks++; if (fetch_pc !== 32'h1c000000) begin errors++; $display("[TB] FAIL reset_pc got %h exp 1c000000", fetch_pc); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", fetch_valid); end
    checks++; if (fetch_mask !== 4'b1111 || fetch_count !== 3'd4) begin errors++; $display("[TB] FAIL reset_mask got %b/%0d exp 1111/4", fetch_mask, fetch_count); end
    checks++; if (pc_is_exception !== 1'b0 || pc_exception_cause !== `EXCEPTION_NOP) begin errors++; $display("[TB] FAIL reset_exc got %b/%h", pc_is_exception, pc_exception_cause); end
    rst_n = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_valid got %b exp 0", fetch_valid); end
    step();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h1c000000) begin errors++; $display("[TB] FAIL first_req got %b/%h exp 1/1c000000", fetch_valid, fetch_pc); end
    step();
    checks++; if (fetch_pc !== 32'h1c000010) begin errors++; $display("[TB] FAIL seq1 got %h exp 1c000010", fetch_pc); end
    step();
    checks++; if (fetch_pc !== 32'h1c000020 || fetch_count !== 3'd4) begin errors++; $display("[TB] FAIL seq2 got %h/%0d exp 1c000020/4", fetch_pc, fetch_count); end
  endtask

  task automatic test_alignment();
    flush = 1; flush_pc = 32'h1c000108;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b exp 0", fetch_valid); end
    step(); flush = 0; #1;
    checks++; if (fetch_pc !== 32'h1c000108 || fetch_count !== 3'd2 || fetch_mask !== 4'b0011) begin errors++; $display("[TB] FAIL partial_block got %h/%0d/%b exp 1c000108/2/0011", fetch_pc, fetch_count, fetch_mask); end
    step();
    checks++; if (fetch_pc !== 32'h1c000110 || fetch_count !== 3'd4) begin errors++; $display("[TB] FAIL after_partial got %h/%0d exp 1c000110/4", fetch_pc, fetch_count); end
    flush = 1; flush_pc = 32'h1c000108; iuncache = 1;
    step(); flush = 0; #1;
    checks++; if (fetch_count !== 3'd1 || fetch_mask !== 4'b0001) begin errors++; $display("[TB] FAIL uncached_count got %0d/%b exp 1/0001", fetch_count, fetch_mask); end
    step();
    checks++; if (fetch_pc !== 32'h1c00010c) begin errors++; $display("[TB] FAIL uncached_next got %h exp 1c00010c", fetch_pc); end
    iuncache = 0; #1;
    checks++; if (fetch_count !== 3'd1) begin errors++; $display("[TB] FAIL last_slot_count got %0d exp 1", fetch_count); end
  endtask

  task automatic test_hold_redirect();
    fetch_ready = 0; stall = 1;
    step();
    checks++; if (fetch_pc !== 32'h1c00010c || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold got %h/%b exp 1c00010c/0", fetch_pc, fetch_valid); end
    stall = 0; bpu_taken = 1; bpu_target = 32'h1c000200; #1;
    checks++; if (fetch_pc !== 32'h1c00010c || fetch_mask !== 4'b0001 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_before_bpu got %h/%b/%b", fetch_pc, fetch_mask, fetch_valid); end
    step(); bpu_taken = 0; #1;
    checks++; if (fetch_pc !== 32'h1c000200 || fetch_mask !== 4'b1111 || fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL bpu_redirect got %h/%b/%b exp 1c000200/1111/1", fetch_pc, fetch_mask, fetch_valid); end
    step(); stall = 1;
    step(); stall = 0;
    step();
    checks++; if (fetch_pc !== 32'h1c000200 || fetch_mask !== 4'b1111) begin errors++; $display("[TB] FAIL not_ready_stable got %h/%b exp 1c000200/1111", fetch_pc, fetch_mask); end
  endtask

  task automatic test_priority();
    fetch_ready = 1; flush = 1; flush_pc = 32'h1c000400; bpu_taken = 1; bpu_target = 32'h1c000800;
    step(); flush = 0; bpu_taken = 0; #1;
    checks++; if (fetch_pc !== 32'h1c000400) begin errors++; $display("[TB] FAIL flush_over_bpu got %h exp 1c000400", fetch_pc); end
    flush = 1; flush_pc = 32'h1c000040;
    step(); flush = 0; #1;
    checks++; if (fetch_pc !== 32'h1c000040) begin errors++; $display("[TB] FAIL flush_over_handshake got %h exp 1c000040", fetch_pc); end
  endtask

  task automatic test_wrap();
    flush = 1; flush_pc = 32'hfffffff0;
    step(); flush = 0;
    step();
    checks++; if (fetch_pc !== 32'h00000000) begin errors++; $display("[TB] FAIL wrap_block got %h exp 00000000", fetch_pc); end
    flush = 1; flush_pc = 32'hfffffffc;
    step(); flush = 0; #1;
    checks++; if (fetch_count !== 3'd1) begin errors++; $display("[TB] FAIL wrap_count got %0d exp 1", fetch_count); end
    step();
    checks++; if (fetch_pc !== 32'h00000000) begin errors++; $display("[TB] FAIL wrap_single got %h exp 00000000", fetch_pc); end
  endtask

  task automatic test_exception();
    flush = 1; flush_pc = 32'h1c000002; fetch_ready = 0;
    step(); flush = 0; #1;
    checks++; if (pc_is_exception !== 1'b1 || pc_exception_cause !== `EXCEPTION_ADEF) begin errors++; $display("[TB] FAIL adef_flag got %b/%h", pc_is_exception, pc_exception_cause); end
    checks++; if (fetch_count !== 3'd1 || fetch_mask !== 4'b0001 || fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL adef_block got %0d/%b/%b exp 1/0001/1", fetch_count, fetch_mask, fetch_valid); end
    fetch_ready = 1;
    step();
    checks++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h1c000002) begin errors++; $display("[TB] FAIL exc_parked got %b/%h exp 0/1c000002", fetch_valid, fetch_pc); end
    bpu_taken = 1; bpu_target = 32'h1c000900;
    step(); bpu_taken = 0; #1;
    checks++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h1c000002) begin errors++; $display("[TB] FAIL exc_ignores_bpu got %b/%h exp 0/1c000002", fetch_valid, fetch_pc); end
    flush = 1; flush_pc = 32'h1c000000;
    step(); flush = 0; #1;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h1c000000 || pc_is_exception !== 1'b0 || pc_exception_cause !== `EXCEPTION_NOP) begin errors++; $display("[TB] FAIL exc_resume got %b/%h/%b/%h", fetch_valid, fetch_pc, pc_is_exception, pc_exception_cause); end
  endtask

  task automatic test_async_reset();
    step();
    rst_n = 0; #1;
    checks++; if (fetch_pc !== 32'h1c000000 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got %h/%b exp 1c000000/0", fetch_pc, fetch_valid); end
    step(); rst_n = 1;
  endtask

`ifdef FETCH_PC_GEN_PERF_EN
  task automatic test_perf();
    rst_n = 0; fetch_ready = 1;
    step(); rst_n = 1;
    step();
    repeat (10) step();
    fetch_ready = 0; flush = 1; flush_pc = 32'h1c000000;
    step(); flush = 0; bpu_taken = 1; bpu_target = 32'h1c000100;
    step(); bpu_taken = 0; #1;
    checks++; if (perf_fetch_blocks !== 32'd10) begin errors++; $display("[TB] FAIL perf_blocks got %0d exp 10", perf_fetch_blocks); end
    checks++; if (perf_redirects !== 32'd2) begin errors++; $display("[TB] FAIL perf_redirects got %0d exp 2", perf_redirects); end
    rst_n = 0; #1;
    checks++; if (perf_fetch_blocks !== 32'd0 || perf_redirects !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset got %0d/%0d exp 0/0", perf_fetch_blocks, perf_redirects); end
    step(); rst_n = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_alignment();
    test_hold_redirect();
    test_priority();
    test_wrap();
    test_exception();
    test_async_reset();
`ifdef FETCH_PC_GEN_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
